// File: rtl/tmr_capture_compare.sv
// Capture/compare consumer for the shared timer count bus: samples the count on an
// external pin edge and flags when the count enters a programmed compare value.
module tmr_capture_compare #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] tmr_val,
    input  logic             cap_in,
    input  logic             cap_edge_sel,
    input  logic             cmp_wr,
    input  logic [WIDTH-1:0] cmp_data,
    input  logic             cap_ack,
    input  logic             cmp_ack,
    output logic [WIDTH-1:0] cap_val,
    output logic             cap_flag,
    output logic             cap_ovf,
    output logic             cmp_match,
    output logic             cmp_flag
);

    localparam int unsigned SETTLE_W   = 2;
    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(3);

    logic                s1;
    logic                s2;
    logic                s3;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [WIDTH-1:0]    cmp_reg;
    logic                prev_eq;

    logic                rise_c;
    logic                fall_c;
    logic                cap_evt_c;
    logic                eq_c;
    logic                cmp_evt_c;

    // Edge qualification: pin edges are ignored until the settle counter saturates
    always_comb begin
        rise_c    = s2 & ~s3;
        fall_c    = ~s2 & s3;
        cap_evt_c = en && (settle_cnt == SETTLE_MAX) && (cap_edge_sel ? rise_c : fall_c);
        eq_c      = (tmr_val == cmp_reg);
        cmp_evt_c = en & eq_c & ~prev_eq;
    end

    // Pin synchronizer plus one stage of edge history; runs regardless of en
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= cap_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if (settle_cnt != SETTLE_MAX) begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
        end
    end

    // Capture: a pending flag preserves the first value; a same-cycle ack lets the new edge win
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_val  <= '0;
            cap_flag <= 1'b0;
            cap_ovf  <= 1'b0;
        end else if (cap_evt_c) begin
            if (!cap_flag || cap_ack) begin
                cap_val  <= tmr_val;
                cap_flag <= 1'b1;
                if (cap_ack) begin
                    cap_ovf <= 1'b0;
                end
            end else begin
                cap_ovf <= 1'b1;
            end
        end else if (cap_ack) begin
            cap_flag <= 1'b0;
            cap_ovf  <= 1'b0;
        end
    end

    // Compare: fires only on entry into equality; prev_eq tracks even while disabled
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_reg   <= '1;
            prev_eq   <= 1'b1;
            cmp_match <= 1'b0;
            cmp_flag  <= 1'b0;
        end else begin
            if (cmp_wr) begin
                cmp_reg <= cmp_data;
            end
            prev_eq   <= eq_c;
            cmp_match <= cmp_evt_c;
            if (cmp_evt_c) begin
                cmp_flag <= 1'b1;
            end else if (cmp_ack) begin
                cmp_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tmr_capture_compare.sv
// Directed bench for tmr_capture_compare: a pin-history/compare-entry model checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_tmr_capture_compare;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] tmr_val;
    logic       cap_in;
    logic       cap_edge_sel;
    logic       cmp_wr;
    logic [7:0] cmp_data;
    logic       cap_ack;
    logic       cmp_ack;
    logic [7:0] cap_val;
    logic       cap_flag;
    logic       cap_ovf;
    logic       cmp_match;
    logic       cmp_flag;

    int checks = 0;
    int errors = 0;
    int match_cnt = 0;

    // Model state
    logic [7:0] m_cap_val;
    logic       m_cap_flag;
    logic       m_cap_ovf;
    logic       m_cmp_match;
    logic       m_cmp_flag;
    logic [7:0] m_cmp;
    logic       m_last_eq;
    int         since_rst;
    bit         pin_q[$];

    tmr_capture_compare #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .tmr_val      (tmr_val),
        .cap_in       (cap_in),
        .cap_edge_sel (cap_edge_sel),
        .cmp_wr       (cmp_wr),
        .cmp_data     (cmp_data),
        .cap_ack      (cap_ack),
        .cmp_ack      (cmp_ack),
        .cap_val      (cap_val),
        .cap_flag     (cap_flag),
        .cap_ovf      (cap_ovf),
        .cmp_match    (cmp_match),
        .cmp_flag     (cmp_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a pin edge counts at edge n when the pin samples from edges n-3 and n-2
    // show it and at least three clean cycles have elapsed since reset.
    task automatic model_step();
        bit a;
        bit b;
        bit ed;
        bit eq;
        bit ev;
        int n;
        pin_q.push_back(cap_in);
        n = pin_q.size();
        if (reset) begin
            m_cap_val   = 8'h00;
            m_cap_flag  = 1'b0;
            m_cap_ovf   = 1'b0;
            m_cmp_match = 1'b0;
            m_cmp_flag  = 1'b0;
            m_cmp       = 8'hFF;
            m_last_eq   = 1'b1;
            since_rst   = 0;
        end else begin
            ed = 1'b0;
            if (since_rst >= 3 && n >= 4) begin
                a  = pin_q[n-3];
                b  = pin_q[n-4];
                ed = cap_edge_sel ? (a && !b) : (!a && b);
            end
            if (en && ed) begin
                if (!m_cap_flag || cap_ack) begin
                    m_cap_val  = tmr_val;
                    m_cap_flag = 1'b1;
                    m_cap_ovf  = 1'b0;
                end else begin
                    m_cap_ovf = 1'b1;
                end
            end else if (cap_ack) begin
                m_cap_flag = 1'b0;
                m_cap_ovf  = 1'b0;
            end
            eq          = (tmr_val == m_cmp);
            ev          = en && eq && !m_last_eq;
            m_cmp_match = ev;
            if (ev) m_cmp_flag = 1'b1;
            else if (cmp_ack) m_cmp_flag = 1'b0;
            m_last_eq = eq;
            if (cmp_wr) m_cmp = cmp_data;
            if (since_rst < 3) since_rst++;
        end
    endtask

    // One clock: sample just after the edge, advance the model, compare all outputs
    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        chk("cap_val",   32'(cap_val),   32'(m_cap_val));
        chk("cap_flag",  32'(cap_flag),  32'(m_cap_flag));
        chk("cap_ovf",   32'(cap_ovf),   32'(m_cap_ovf));
        chk("cmp_match", 32'(cmp_match), 32'(m_cmp_match));
        chk("cmp_flag",  32'(cmp_flag),  32'(m_cmp_flag));
        if (cmp_match === 1'b1) match_cnt++;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; tmr_val = 8'h00; cap_in = 1'b1; cap_edge_sel = 1'b1;
        cmp_wr = 1'b0; cmp_data = 8'h00; cap_ack = 1'b0; cmp_ack = 1'b0;

        // 1: pin high through reset never captures
        tick(); tick();
        chk("rst_cap_val",   32'(cap_val),   32'h0);
        chk("rst_cap_flag",  32'(cap_flag),  32'h0);
        chk("rst_cmp_match", 32'(cmp_match), 32'h0);
        chk("rst_cmp_flag",  32'(cmp_flag),  32'h0);
        reset = 1'b0;
        repeat (10) tick();
        chk("t1_cap_flag", 32'(cap_flag), 32'h0);
        chk("t1_cap_val",  32'(cap_val),  32'h0);
        cap_in = 1'b0;
        repeat (4) tick();

        // 2: rise sampled with count 0x14 lands count 0x16
        for (int i = 0; i < 9; i++) begin
            tmr_val = 8'(8'h10 + i);
            if (i == 4) cap_in = 1'b1;
            tick();
        end
        chk("t2_cap_val",  32'(cap_val),  32'h16);
        chk("t2_cap_flag", 32'(cap_flag), 32'h1);
        cap_ack = 1'b1; tick(); cap_ack = 1'b0;
        chk("t2_ack_flag", 32'(cap_flag), 32'h0);

        // 3: second rise without ack keeps first value and sets overflow
        cap_in = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 12; i++) begin
            tmr_val = 8'(8'h30 + i);
            cap_in  = (i < 3) || (i >= 6 && i < 9);
            tick();
        end
        chk("t3_cap_val",  32'(cap_val),  32'h32);
        chk("t3_cap_flag", 32'(cap_flag), 32'h1);
        chk("t3_cap_ovf",  32'(cap_ovf),  32'h1);
        cap_ack = 1'b1; tick(); cap_ack = 1'b0;
        chk("t3_ack_flag", 32'(cap_flag), 32'h0);
        chk("t3_ack_ovf",  32'(cap_ovf),  32'h0);

        // 4: falling edges; final one coincides with ack and wins
        cap_edge_sel = 1'b0;
        cap_in = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 15; i++) begin
            tmr_val = 8'(8'h40 + i);
            cap_in  = (i == 3) || (i == 4) || (i == 8) || (i == 9);
            cap_ack = (i == 12);
            tick();
            if (i == 9) begin
                chk("t4_ovf_set", 32'(cap_ovf), 32'h1);
                chk("t4_first",   32'(cap_val), 32'h42);
            end
        end
        cap_ack = 1'b0;
        chk("t4_cap_val",  32'(cap_val),  32'h4C);
        chk("t4_cap_flag", 32'(cap_flag), 32'h1);
        chk("t4_cap_ovf",  32'(cap_ovf),  32'h0);
        cap_ack = 1'b1; tick(); cap_ack = 1'b0;
        cap_edge_sel = 1'b1;
        tick();

        // 5: single compare pulse on entry, none while frozen on the value
        tmr_val = 8'h1D; cmp_wr = 1'b1; cmp_data = 8'h20; tick(); cmp_wr = 1'b0;
        match_cnt = 0;
        for (int v = 8'h1E; v <= 8'h20; v++) begin
            tmr_val = 8'(v);
            tick();
        end
        repeat (5) tick();
        tmr_val = 8'h21; tick();
        tmr_val = 8'h22; tick();
        chk("t5_match_cnt", 32'(match_cnt), 32'd1);
        chk("t5_cmp_flag",  32'(cmp_flag),  32'h1);
        cmp_ack = 1'b1; tick(); cmp_ack = 1'b0;
        chk("t5_ack_flag",  32'(cmp_flag),  32'h0);

        // 6: disabled events are lost; re-enable or rewrite while equal gives nothing
        en = 1'b0; match_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tmr_val = 8'(8'h1C + i);
            cap_in  = (i % 2 == 1);
            tick();
        end
        tmr_val = 8'h20;
        repeat (4) tick();
        chk("t6_cap_flag",  32'(cap_flag),  32'h0);
        chk("t6_cmp_flag",  32'(cmp_flag),  32'h0);
        chk("t6_match_off", 32'(match_cnt), 32'd0);
        en = 1'b1;
        repeat (3) tick();
        chk("t6_match_en",  32'(match_cnt), 32'd0);
        cmp_wr = 1'b1; cmp_data = 8'h20; tick(); cmp_wr = 1'b0;
        repeat (3) tick();
        chk("t6_match_wr",  32'(match_cnt), 32'd0);
        chk("t6_cmp_flag2", 32'(cmp_flag),  32'h0);

        // 7: write equal to current count fires one cycle later; event beats ack
        tmr_val = 8'h55; tick();
        match_cnt = 0;
        cmp_wr = 1'b1; cmp_data = 8'h55; tick(); cmp_wr = 1'b0;
        cmp_ack = 1'b1; tick(); cmp_ack = 1'b0;
        chk("t7_match",     32'(cmp_match), 32'h1);
        chk("t7_cmp_flag",  32'(cmp_flag),  32'h1);
        repeat (2) tick();
        chk("t7_match_cnt", 32'(match_cnt), 32'd1);

        // 8: compare at all ones across wrap-around
        cmp_wr = 1'b1; cmp_data = 8'hFF; tick(); cmp_wr = 1'b0;
        cmp_ack = 1'b1; tick(); cmp_ack = 1'b0;
        match_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tmr_val = 8'(8'hFD + i);
            tick();
        end
        chk("t8_match_cnt", 32'(match_cnt), 32'd1);
        chk("t8_cmp_flag",  32'(cmp_flag),  32'h1);

        // 9: reset mid-operation drops an in-flight pin edge and clears flags
        cap_in = 1'b0;
        repeat (3) tick();
        cap_in = 1'b1; tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t9_rst_cmp_flag", 32'(cmp_flag), 32'h0);
        repeat (6) tick();
        chk("t9_cap_flag", 32'(cap_flag), 32'h0);
        chk("t9_cap_val",  32'(cap_val),  32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
